regfile_scan_reader: RTL

//  Read-side master for the 8x8 register file (rsel/q port). On a start pulse it

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scan_reader.sv | 105 ++++++++++
 2 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file geometry and scan-reader state encoding.
package regfile_pkg;

  localparam int unsigned REGFILE_AW = 3;
  localparam int unsigned REGFILE_DW = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_OUT  = 2'd2,
    S_DONE = 2'd3
  } scan_state_e;

endpackage

// File: rtl/regfile_scan_reader.sv
// Walks a wrapping address window of the register file and streams each word over valid/ready.
// Optional running XOR checksum is enabled by defining REGFILE_SCAN_CHKSUM_EN.
module regfile_scan_reader
  import regfile_pkg::*;
#(
  parameter int unsigned AW = REGFILE_AW,
  parameter int unsigned DW = REGFILE_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] count,
  input  logic          abort,
  output logic [AW-1:0] rsel,
  input  logic [DW-1:0] q,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] chksum
);

  scan_state_e state_q;
  // One extra bit so a full-depth scan (count=0) fits.
  logic [AW:0] remaining_q;
  logic        accept;
  logic        scan_start;

  assign scan_start = (state_q == S_IDLE) && start;
  // abort wins over a same-cycle handshake.
  assign accept     = (state_q == S_OUT) && out_ready && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      rsel        <= '0;
      out_data    <= '0;
      out_addr    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort && (state_q != S_IDLE)) begin
      state_q   <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            rsel        <= base;
            remaining_q <= (count == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, count};
            busy        <= 1'b1;
            state_q     <= S_READ;
          end
        end
        S_READ: begin
          out_data  <= q;
          out_addr  <= rsel;
          out_valid <= 1'b1;
          state_q   <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            remaining_q <= remaining_q - (AW + 1)'(1);
            if (remaining_q == (AW + 1)'(1)) begin
              done    <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rsel    <= rsel + AW'(1);
              state_q <= S_READ;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef REGFILE_SCAN_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || scan_start) begin
      chksum <= '0;
    end else if (accept) begin
      chksum <= chksum ^ out_data;
    end
  end
`else
  assign chksum = '0;
  logic unused_chk;
  assign unused_chk = ^{scan_start, accept};
`endif

endmodule
